// File: rtl/cla_adder_sched.sv
// Digit-serial adder scheduler: two requesters share one SLICE-bit CLA slice.
// Optional macro SCHED_OVF_EN adds the rsp_ovf signed-overflow output.
module cla_adder_sched #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
`ifdef SCHED_OVF_EN
    output logic             rsp_ovf,
`endif
    output logic             busy
);

    localparam int NDIG = WIDTH / SLICE;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_cfg
            $error("cla_adder_sched: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic              rr_last;
    logic [KW-1:0]     k;
    logic              carry;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              gnt_vld;
    logic              gnt_id;
    logic              last;

    logic [SLICE-1:0]  da;
    logic [SLICE-1:0]  db;
    logic [SLICE-1:0]  dg;
    logic [SLICE-1:0]  dp;
    logic [SLICE-1:0]  ds;
    logic [SLICE:0]    dc;
    logic              cc;
    logic              pp;

    // Round-robin: on contention the requester not served last wins.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid) gnt_id = ~rr_last;
        else if (req1_valid)          gnt_id = 1'b1;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !gnt_id;
    assign req1_ready = (state == IDLE) && req1_valid && gnt_id;
    assign busy       = (state != IDLE);
    assign last       = (k == KW'(NDIG - 1));

    // Flattened lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
    always_comb begin
        da = a_q[int'(k)*SLICE +: SLICE];
        db = b_q[int'(k)*SLICE +: SLICE];
        dg = da & db;
        dp = da ^ db;
        dc = '0;
        cc = 1'b0;
        pp = 1'b1;
        dc[0] = carry;
        for (int i = 0; i < SLICE; i++) begin
            cc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                pp = 1'b1;
                for (int m = j + 1; m <= i; m++) pp = pp & dp[m];
                cc = cc | (dg[j] & pp);
            end
            pp = 1'b1;
            for (int m = 0; m <= i; m++) pp = pp & dp[m];
            dc[i+1] = cc | (pp & carry);
        end
        ds = dp ^ dc[SLICE-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_vld) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last   <= 1'b1;
            k         <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= 1'b0;
`ifdef SCHED_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        a_q     <= gnt_id ? req1_a : req0_a;
                        b_q     <= gnt_id ? req1_b : req0_b;
                        carry   <= gnt_id ? req1_cin : req0_cin;
                        k       <= '0;
                        rr_last <= gnt_id;
                        rsp_id  <= gnt_id;
                    end
                end
                RUN: begin
                    rsp_sum[int'(k)*SLICE +: SLICE] <= ds;
                    carry <= dc[SLICE];
                    k     <= k + 1'b1;
                    if (last) begin
                        rsp_cout  <= dc[SLICE];
                        rsp_valid <= 1'b1;
`ifdef SCHED_OVF_EN
                        rsp_ovf   <= dc[SLICE] ^ dc[SLICE-1];
`endif
                    end
                end
                DONE: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_adder_sched.sv
// Directed self-checking bench for cla_adder_sched (8/2 and 2/2 builds).
// Define SCHED_OVF_EN to also check rsp_ovf.
module tb_cla_adder_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0v = 1'b0, r1v = 1'b0, r0c = 1'b0, r1c = 1'b0, rr = 1'b0;
    logic [7:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
    logic       r0_rdy, r1_rdy, rsp_valid, rsp_cout, rsp_id, busy;
    logic [7:0] rsp_sum;
    logic       ovf;

    logic       nv = 1'b0, nc = 1'b0, nrr = 1'b0;
    logic [1:0] na = '0, nb = '0;
    logic       n_rdy, n_rdy1, n_valid, n_cout, n_id, n_busy;
    logic [1:0] n_sum;
    logic       n_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_adder_sched #(.WIDTH(8), .SLICE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0_rdy),
        .req0_a(r0a), .req0_b(r0b), .req0_cin(r0c),
        .req1_valid(r1v), .req1_ready(r1_rdy),
        .req1_a(r1a), .req1_b(r1b), .req1_cin(r1c),
        .rsp_valid(rsp_valid), .rsp_ready(rr),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
`ifdef SCHED_OVF_EN
        .rsp_ovf(ovf),
`endif
        .busy(busy)
    );

    cla_adder_sched #(.WIDTH(2), .SLICE(2)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(nv), .req0_ready(n_rdy),
        .req0_a(na), .req0_b(nb), .req0_cin(nc),
        .req1_valid(1'b0), .req1_ready(n_rdy1),
        .req1_a(2'b00), .req1_b(2'b00), .req1_cin(1'b0),
        .rsp_valid(n_valid), .rsp_ready(nrr),
        .rsp_sum(n_sum), .rsp_cout(n_cout), .rsp_id(n_id),
`ifdef SCHED_OVF_EN
        .rsp_ovf(n_ovf),
`endif
        .busy(n_busy)
    );

`ifndef SCHED_OVF_EN
    assign ovf   = 1'b0;
    assign n_ovf = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One full transaction on the wide instance; caller sets up requesters.
    task automatic serve(input logic eid, input logic [7:0] esum,
                         input logic ecout, input logic eovf,
                         input bit keep, input int hold);
        int n;
        #1;
        n = 0;
        while (!(r0_rdy || r1_rdy) && n < 10) begin
            tick();
            n++;
        end
        chk("grant", {30'd0, r1_rdy, r0_rdy}, eid ? 32'd2 : 32'd1);
        if (!(r0_rdy || r1_rdy)) return;
        tick();
        if (!keep) begin
            if (eid) r1v = 1'b0;
            else     r0v = 1'b0;
        end
        chk("ready_low_run", {30'd0, r1_rdy, r0_rdy}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", n, 4);
        chk("sum", rsp_sum, esum);
        chk("cout", rsp_cout, ecout);
        chk("id", rsp_id, eid);
`ifdef SCHED_OVF_EN
        chk("ovf", ovf, eovf);
`else
        if (eovf !== ovf && 1'b0 === ovf) n = n;
`endif
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_sum", rsp_sum, esum);
            chk("hold_cout", rsp_cout, ecout);
            chk("hold_id", rsp_id, eid);
            chk("hold_busy", busy, 1);
            chk("hold_ready", {30'd0, r1_rdy, r0_rdy}, 32'd0);
        end
        rr = 1'b1;
        tick();
        rr = 1'b0;
        chk("release_valid", rsp_valid, 0);
        chk("release_busy", busy, 0);
    endtask

    initial begin
        int n;
        bit seen;
        logic [2:0] exp3;

        do_reset();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_cout", rsp_cout, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready0", r0_rdy, 0);

        // Reset in the second RUN cycle abandons the operation.
        r0a = 8'h55; r0b = 8'h22; r0c = 1'b0; r0v = 1'b1;
        #1;
        chk("mr_ready", r0_rdy, 1);
        tick();
        r0v = 1'b0;
        chk("mr_busy_run", busy, 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_valid", rsp_valid, 0);
        chk("mr_sum", rsp_sum, 0);
        chk("mr_cout", rsp_cout, 0);
        chk("mr_id", rsp_id, 0);
        chk("mr_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        chk("mr_no_rsp", seen, 0);
        r0v = 1'b1;
        #1;
        chk("mr_ready_after", r0_rdy, 1);
        r0v = 1'b0;

        // Single op.
        r0a = 8'hFF; r0b = 8'h01; r0c = 1'b0; r0v = 1'b1;
        serve(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);

        // Contention after reset, grants alternate.
        do_reset();
        r0a = 8'h03; r0b = 8'h04; r0c = 1'b0; r0v = 1'b1;
        r1a = 8'h80; r1b = 8'h80; r1c = 1'b1; r1v = 1'b1;
        serve(1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 0);
        serve(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 0);
        serve(1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 0);
        serve(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 0);
        r0v = 1'b0;
        tick();
        tick();
        tick();
        tick();
        if (rsp_valid) begin
            rr = 1'b1;
            tick();
            rr = 1'b0;
        end
        do_reset();

        // Backpressure: five stalled cycles in DONE.
        r1a = 8'h12; r1b = 8'h34; r1c = 1'b0; r1v = 1'b1;
        serve(1'b1, 8'h46, 1'b0, 1'b0, 1'b0, 5);

        // Carry-in and signed overflow.
        r1a = 8'h7F; r1b = 8'h00; r1c = 1'b1; r1v = 1'b1;
        serve(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 0);
        r1a = 8'hFF; r1b = 8'hFF; r1c = 1'b1; r1v = 1'b1;
        serve(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0);

        // Single-digit build: exhaustive sweep with cin=1.
        nc = 1'b1;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                na = a[1:0];
                nb = b[1:0];
                nv = 1'b1;
                #1;
                chk("n_ready", n_rdy, 1);
                tick();
                nv = 1'b0;
                n = 0;
                while (!n_valid && n < 10) begin
                    tick();
                    n++;
                end
                chk("n_latency", n, 1);
                exp3 = 3'(a) + 3'(b) + 3'd1;
                chk("n_sum", {n_cout, n_sum}, exp3);
                nrr = 1'b1;
                tick();
                nrr = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
